// File: rtl/wide_add_sequencer_pkg.sv
// Shared FSM state encoding and default geometry for the wide add sequencer.
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

endpackage

// File: rtl/wide_add_sequencer_rca_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Latency 0; no flow control.
module rca_slice
  import wide_add_sequencer_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle a+b+cin, one SLICE-bit slice per cycle, LSB first; OVF_FLAG_EN adds a signed-overflow output.
// Latency WIDTH/SLICE cycles from accept to out_valid; in_ready only in IDLE, result held until out_ready.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic [SLICE-1:0] s_sum;
  logic            s_cout;
  logic            last;

  assign last = (idx == IW'(N - 1));

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[idx*SLICE +: SLICE]),
    .b    (b_q[idx*SLICE +: SLICE]),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)       state_nxt = ST_RUN;
      ST_RUN:  if (last)           state_nxt = ST_DONE;
      ST_DONE: if (out_ready)      state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx     <= '0;
        end
        ST_RUN: begin
          sum[idx*SLICE +: SLICE] <= s_sum;
          carry_q                 <= s_cout;
          idx                     <= idx + 1'b1;
          if (last) cout <= s_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef OVF_FLAG_EN
  // Carry into the MSB is recovered from the MSB's own a^b^sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == ST_RUN && last) begin
      ovf <= (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_sum[SLICE-1]) ^ s_cout;
    end
  end
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed plus random adds against a plain-arithmetic reference (WIDTH=16, SLICE=4).
module tb_wide_add_sequencer;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVF_FLAG_EN
  logic             ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for result, hold for 'hold' cycles, release.
  task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tcin, input int hold);
    logic [WIDTH:0]   ref_full;
    logic [WIDTH-1:0] ref_sum;
    logic             ref_cout;
    int               cyc;
    ref_full = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tcin};
    ref_sum  = ref_full[WIDTH-1:0];
    ref_cout = ref_full[WIDTH];

    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    // Operands change after the accept edge while in_valid stays high; must be ignored.
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(N));
    chk("sum", 32'(sum), 32'(ref_sum));
    chk("cout", 32'(cout), 32'(ref_cout));
`ifdef OVF_FLAG_EN
    chk("ovf", 32'(ovf), 32'((ta[WIDTH-1] == tb_[WIDTH-1]) && (ref_sum[WIDTH-1] != ta[WIDTH-1])));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(ref_sum));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("idle_sum_kept", 32'(sum), 32'(ref_sum));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    // out_ready while idle must not disturb anything.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready_noeffect", 32'(out_valid), 32'd0);

    do_add(16'h1234, 16'h1111, 1'b0, 0);
    do_add(16'hFFFF, 16'h0001, 1'b0, 1);
    do_add(16'h000F, 16'h0000, 1'b1, 0);
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 5);
    do_add(16'h7FFF, 16'h0001, 1'b0, 0);
    do_add(16'h8000, 16'h8000, 1'b0, 0);

    // Reset while slice 2 is being added.
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    do_add(16'h0001, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 25; k++) begin
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
